// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_BLANK    : all segments off (active-low pins), dp off
//   GLYPH_TABLE  : 16 active-low hex glyphs {dp,g,f,e,d,c,b,a} with dp off
//   slot_state_e : per-digit slot phase (dead-time, then lit)
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] GLYPH_TABLE [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_lut.sv
// Combinational hex-to-seven-segment decoder (active-low).
//   nibble : 4-bit hex value
//   seg    : active-low segments {g,f,e,d,c,b,a}
module seg_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = GLYPH_TABLE[nibble];
    seg   = glyph[6:0];
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A packed hex word is written through a valid/ready port into a shadow
// register and committed to the displayed value only when the scan wraps
// back to digit 0, so a frame never mixes old and new digits.
//
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   wr_valid     : write request
//   wr_ready     : shadow register empty
//   wr_data      : hex nibbles, nibble i -> digit i (digit 0 = LSD)
//   wr_dp        : decimal-point enables, captured with wr_data
//   digit_en     : live per-digit enable
//   lz_blank     : live leading-zero blanking enable
//   an_n         : active-low anode selects (at most one low), registered
//   seg_n        : active-low segments {dp,g,f,e,d,c,b,a}, registered
//   frame_done   : one-cycle pulse in the cycle after the scan wraps to digit 0
//   slot_state   : current slot phase, for observation
//
// Handshake: a write transfers on a rising clk edge where wr_valid and
// wr_ready are both 1. wr_ready is 1 exactly when the shadow register is
// empty; wr_data/wr_dp are ignored while wr_ready is 0. The shadow empties
// on the frame wrap, and wr_ready is seen high from the following cycle.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [7:0]              seg_n,
  output logic                    frame_done,
  output slot_state_e             slot_state
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] COUNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // With no dead-time the slot is lit from its first cycle.
  localparam slot_state_e SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  assign tick = (count == COUNT_LAST);
  // The tick on the last digit is the frame boundary.
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      idx   <= '0;
    end else if (tick) begin
      count <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot state machine: BLANK for the first BLANK_CYCLES counts of each slot,
  // SHOW for the remainder. It always agrees with the prescaler count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_state <= SLOT_START;
    end else begin
      case (slot_state)
        ST_BLANK: if (count == BLANK_LAST) slot_state <= ST_SHOW;
        ST_SHOW:  if (tick)                slot_state <= SLOT_START;
        default:                           slot_state <= SLOT_START;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write port, shadow register and frame commit
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    shadow_full;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    wr_fire;

  assign wr_ready = !shadow_full;
  assign wr_fire  = wr_valid && wr_ready;

  // A write and a commit never coincide: a commit needs a full shadow,
  // and a write needs an empty one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val  <= '0;
      shadow_dp   <= '0;
      shadow_full <= 1'b0;
      active_val  <= '0;
      active_dp   <= '0;
    end else if (wrap && shadow_full) begin
      active_val  <= shadow_val;
      active_dp   <= shadow_dp;
      shadow_full <= 1'b0;
    end else if (wr_fire) begin
      shadow_val  <= wr_data;
      shadow_dp   <= wr_dp;
      shadow_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= wrap;
  end

  // ---------------------------------------------------------------------------
  // Digit selection and blanking
  // ---------------------------------------------------------------------------
  logic [3:0]            sel_nibble;
  logic                  sel_dp;
  logic                  sel_en;
  logic                  sel_lz;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic                  visible;
  logic [6:0]            glyph_seg;

  // lz_mask[k] is set when nibbles NUM_DIGITS-1..k of the active value are all
  // zero. Digit 0 is never marked so a value of zero still shows one "0".
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (active_val[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    sel_en     = 1'b0;
    sel_lz     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        sel_nibble = active_val[4*k +: 4];
        sel_dp     = active_dp[k];
        sel_en     = digit_en[k];
        sel_lz     = lz_mask[k];
      end
    end
  end

  assign visible = (slot_state == ST_SHOW) && sel_en && !(lz_blank && sel_lz);

  seg_hex_lut u_lut (
    .nibble (sel_nibble),
    .seg    (glyph_seg)
  );

  // ---------------------------------------------------------------------------
  // Registered pin drivers, one cycle behind the count/index they reflect.
  // A dark slot still occupies its full time.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_next;

  always_comb begin
    an_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (visible && (idx == IW'(k))) an_next[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= an_next;
      seg_n <= visible ? {~sel_dp, glyph_seg} : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (4 digits, 8 cycles per slot, 2 dead cycles).
// A reference model derives the expected pins from elapsed time since reset
// and the written words; each cycle's expectation goes into exp_q and a
// monitor on the falling edge pops and compares against the pins.
module tb_seven_seg_scan_ctrl;
  import seven_seg_pkg::*;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [4*ND-1:0] wr_data = '0;
  logic [ND-1:0] wr_dp = '0;
  logic [ND-1:0] digit_en = '1;
  logic          lz_blank = 1'b0;
  logic [ND-1:0] an_n;
  logic [7:0]    seg_n;
  logic          frame_done;
  slot_state_e   slot_state;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .frame_done (frame_done),
    .slot_state (slot_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected pin word: {an_n[3:0], seg_n[7:0], frame_done, wr_ready}
  localparam int W = ND + 10;
  logic [W-1:0] exp_q[$];

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time-based view of the scan plus the shadow/active words.
  // ---------------------------------------------------------------------------
  int              m_t;
  logic [4*ND-1:0] m_active, m_shadow;
  logic [ND-1:0]   m_adp, m_sdp;
  bit              m_full;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_t = 0; m_active = '0; m_adp = '0; m_shadow = '0; m_sdp = '0; m_full = 0;
      end else begin
        int pos, dig;
        bit at_wrap, lz, vis;
        logic [ND-1:0] e_an;
        logic [7:0]    e_seg;
        logic [3:0]    nib;
        pos     = m_t % RD;
        dig     = (m_t / RD) % ND;
        at_wrap = (pos == RD - 1) && (dig == ND - 1);
        nib     = 4'((m_active >> (4 * dig)) & 16'hF);
        lz      = lz_blank && (dig != 0) && ((m_active >> (4 * dig)) == 0);
        vis     = (pos >= BC) && digit_en[dig] && !lz;
        e_an    = vis ? ~(ND'(1) << dig) : '1;
        e_seg   = vis ? {~m_adp[dig], glyph[nib]} : 8'hFF;
        if (at_wrap && m_full) begin
          m_active = m_shadow; m_adp = m_sdp; m_full = 0;
        end else if (wr_valid && !m_full) begin
          m_shadow = wr_data; m_sdp = wr_dp; m_full = 1;
        end
        exp_q.push_back({e_an, e_seg, at_wrap, !m_full});
        m_t++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("pins", {an_n, seg_n, frame_done, wr_ready}, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4*ND-1:0] d, input logic [ND-1:0] dp);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      if (wr_ready) begin
        wr_valid = 1'b1; wr_data = d; wr_dp = dp;
        @(negedge clk); #1;
        wr_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout: wr_ready stayed %b, expected 1", wr_ready);
    end
  endtask

  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    #1;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL frame_timeout: frame_done stayed 0, expected 1");
    end
  endtask

  task automatic async_reset_check();
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_an_n", an_n, 4'hF);
    check("rst_seg_n", seg_n, 8'hFF);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    exp_q.delete();
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("init_an_n", an_n, 4'hF);
    check("init_seg_n", seg_n, 8'hFF);
    check("init_wr_ready", wr_ready, 1'b1);
    check("init_frame_done", frame_done, 1'b0);
    reset = 1'b0;

    // Basic display of 1234, all digits on.
    digit_en = 4'hF; lz_blank = 1'b0;
    do_write(16'h1234, 4'b0000);
    wait_frame();
    idle(70);

    // Second word held while the shadow is full.
    do_write(16'h5678, 4'b0000);
    wr_valid = 1'b1; wr_data = 16'hABCD; wr_dp = 4'b1111;
    idle(6);
    check("held_wr_ready", wr_ready, 1'b0);
    idle(40);
    wr_valid = 1'b0;
    idle(40);

    // Leading-zero blanking on and off.
    do_write(16'h0005, 4'b0000);
    lz_blank = 1'b1;
    wait_frame();
    idle(40);
    lz_blank = 1'b0;
    idle(40);
    do_write(16'h0000, 4'b0001);
    lz_blank = 1'b1;
    wait_frame();
    idle(40);

    // Per-digit enable and decimal point.
    do_write(16'h8888, 4'b0010);
    digit_en = 4'b1010;
    wait_frame();
    idle(40);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      digit_en = 4'($urandom_range(0, 15));
      lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        do_write(16'($urandom), 4'($urandom));
      end else begin
        wr_valid = 1'b1; wr_data = 16'($urandom); wr_dp = 4'($urandom);
        idle($urandom_range(1, 20));
        wr_valid = 1'b0;
      end
      idle($urandom_range(1, 40));
    end

    // Reset mid-slot with a pending shadow word.
    digit_en = 4'hF; lz_blank = 1'b0;
    do_write(16'h9999, 4'b1111);
    wait_frame();
    do_write(16'h7777, 4'b0000);
    idle(3);
    async_reset_check();
    idle(70);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a bug wedges the stimulus.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
